// File: rtl/timer_counter.sv
// rtl/timer_counter.sv - memory-mapped programmable down-counter with interrupt
//
// Purpose:
//   Down-counter programmed through word-aligned bridge accesses. One-shot
//   mode holds its interrupt until software rewrites CTRL or PRESET; periodic
//   mode (Mode 1) reloads from PRESET and emits a one-cycle interrupt pulse.
//
// Register map (addr[3:2]):
//   0 CTRL   [0] Enable, [2:1] Mode, [3] IM (interrupt mask); [31:4] read 0
//   1 PRESET read/write reload value
//   2 COUNT  read-only current count
//   3 reserved, reads 0, writes ignored
//
// Ports:
//   clk           system clock, all state updates on posedge
//   reset         synchronous, active-high reset
//   addr          byte address, only addr[3:2] decoded
//   write_enable  bridge-gated store to this device this cycle
//   write_data    store data
//   read_data     combinational read of the selected register
//   IRQ           interrupt request (CTRL.IM & irq_flag)

module timer_counter #(
  parameter int COUNT_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        write_enable,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        IRQ
);

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;

  localparam logic [COUNT_W-1:0] ONE = COUNT_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    CNT,
    INT
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic               ctrl_en;
  logic               en_nxt;
  logic [1:0]         ctrl_mode;
  logic               ctrl_im;
  logic [COUNT_W-1:0] preset;
  logic [COUNT_W-1:0] count;
  logic [COUNT_W-1:0] count_nxt;
  logic               irq_flag;
  logic               flag_nxt;

  logic [1:0]         sel;
  logic               cpu_wr;
  logic [31:0]        preset_ext;
  logic [31:0]        count_ext;
  logic               unused_addr_bits;

  assign sel              = addr[3:2];
  assign unused_addr_bits = ^{addr[31:4], addr[1:0]};

  // Only CTRL and PRESET writes take effect; COUNT and reserved writes are
  // dropped and let the counter keep running.
  assign cpu_wr = write_enable && ((sel == ADDR_CTRL) || (sel == ADDR_PRESET));

  // Next state of the counter when no CPU write preempts it.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    flag_nxt  = irq_flag;
    en_nxt    = ctrl_en;
    case (state)
      IDLE: begin
        if (ctrl_en) state_nxt = LOAD;
      end
      LOAD: begin
        count_nxt = preset;
        state_nxt = CNT;
      end
      CNT: begin
        if (!ctrl_en) begin
          state_nxt = IDLE;
        end else if (count > ONE) begin
          count_nxt = count - ONE;
        end else begin
          // PRESET of 0 lands here too, so it behaves like PRESET of 1.
          count_nxt = '0;
          flag_nxt  = 1'b1;
          state_nxt = INT;
        end
      end
      INT: begin
        if (ctrl_mode == 2'd1) begin
          flag_nxt  = 1'b0;
          state_nxt = LOAD;
        end else begin
          en_nxt    = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ctrl_en   <= 1'b0;
      ctrl_mode <= 2'd0;
      ctrl_im   <= 1'b0;
      preset    <= '0;
      count     <= '0;
      irq_flag  <= 1'b0;
    end else if (cpu_wr) begin
      // A software write overrides every counter update this cycle,
      // including the one-shot Enable auto-clear.
      if (sel == ADDR_CTRL) begin
        ctrl_en   <= write_data[0];
        ctrl_mode <= write_data[2:1];
        ctrl_im   <= write_data[3];
      end else begin
        preset <= write_data[COUNT_W-1:0];
      end
      irq_flag <= 1'b0;
      state    <= IDLE;
    end else begin
      state    <= state_nxt;
      count    <= count_nxt;
      irq_flag <= flag_nxt;
      ctrl_en  <= en_nxt;
    end
  end

  always_comb begin
    preset_ext              = '0;
    preset_ext[COUNT_W-1:0] = preset;
    count_ext               = '0;
    count_ext[COUNT_W-1:0]  = count;
  end

  always_comb begin
    read_data = '0;
    case (sel)
      ADDR_CTRL:   read_data = {28'd0, ctrl_im, ctrl_mode, ctrl_en};
      ADDR_PRESET: read_data = preset_ext;
      ADDR_COUNT:  read_data = count_ext;
      default:     read_data = '0;
    endcase
  end

  assign IRQ = ctrl_im & irq_flag;

endmodule

// File: tb/tb_timer_counter.sv
// tb/tb_timer_counter.sv - self-checking bench for timer_counter

module tb_timer_counter;

  logic        clk;
  logic        reset;
  logic [31:0] addr;
  logic        write_enable;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        IRQ;

  int errors = 0;
  int checks = 0;

  timer_counter #(.COUNT_W(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .addr         (addr),
    .write_enable (write_enable),
    .write_data   (write_data),
    .read_data    (read_data),
    .IRQ          (IRQ)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference model: the counter is described by how many edges have passed
  // since it was (re)started. Phase -1 means stopped.
  logic        m_en;
  logic [1:0]  m_mode;
  logic        m_im;
  logic [31:0] m_preset;
  logic [31:0] m_count;
  logic        m_flag;
  int          m_phase;

  task automatic model_reset();
    m_en = 0; m_mode = 0; m_im = 0;
    m_preset = 0; m_count = 0; m_flag = 0; m_phase = -1;
  endtask

  task automatic model_edge(input bit rst, input bit we, input logic [1:0] sel,
                            input logic [31:0] d);
    longint n;
    if (rst) begin
      model_reset();
    end else if (we && sel <= 2'd1) begin
      if (sel == 2'd0) {m_im, m_mode, m_en} = d[3:0];
      else m_preset = d;
      m_flag  = 0;
      m_phase = m_en ? 0 : -1;
    end else if (m_phase >= 0) begin
      n = (m_preset == 0) ? 1 : longint'(m_preset);
      m_phase++;
      if (m_phase == 2) begin
        m_count = m_preset;
      end else if (m_phase > 2 && m_phase < n + 2) begin
        m_count = m_preset - 32'(m_phase - 2);
      end else if (m_phase == n + 2) begin
        m_count = 0;
        m_flag  = 1;
      end else if (m_phase > 2) begin
        if (m_mode == 2'd1) begin
          m_flag  = 0;
          m_phase = 1;
        end else begin
          m_en    = 0;
          m_phase = -1;
        end
      end
    end
  endtask

  function automatic logic [31:0] m_read(input logic [1:0] sel);
    case (sel)
      2'd0:    return {28'd0, m_im, m_mode, m_en};
      2'd1:    return m_preset;
      2'd2:    return m_count;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic m_irq();
    return m_im & m_flag;
  endfunction

  task automatic step(input bit we, input logic [31:0] a, input logic [31:0] d);
    write_enable = we;
    addr         = a;
    write_data   = d;
    @(posedge clk);
    model_edge(reset, we, a[3:2], d);
    #1;
    write_enable = 0;
    write_data   = 0;
  endtask

  task automatic rd(input logic [1:0] sel, output logic [31:0] v);
    addr = {28'd0, sel, 2'b00};
    #1;
    v = read_data;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    reset = 1;
    step(0, 0, 0);
    reset = 0;
    for (int s = 0; s < 4; s++) begin
      rd(2'(s), v);
      checks++;
      if (v !== 32'd0) begin
        errors++;
        $display("FAIL reset_read[%0d] got %h expected %h", s, v, 32'd0);
      end
    end
    checks++;
    if (IRQ !== 1'b0) begin
      errors++;
      $display("FAIL reset_irq got %b expected 0", IRQ);
    end
  endtask

  task automatic test_oneshot();
    logic [31:0] v;
    step(1, 32'h4, 5);
    step(1, 32'h0, 32'h9);
    for (int k = 1; k <= 10; k++) begin
      step(0, 0, 0);
      rd(2'd2, v);
      checks++;
      if (v !== m_read(2'd2)) begin
        errors++;
        $display("FAIL oneshot_count E%0d got %0d expected %0d", k, v, m_read(2'd2));
      end
      checks++;
      if (IRQ !== m_irq()) begin
        errors++;
        $display("FAIL oneshot_irq E%0d got %b expected %b", k, IRQ, m_irq());
      end
      if (k == 7) begin
        checks++;
        if (v !== 32'd0 || IRQ !== 1'b1) begin
          errors++;
          $display("FAIL oneshot_e7 count %0d irq %b expected count 0 irq 1", v, IRQ);
        end
      end
    end
    rd(2'd0, v);
    checks++;
    if (v !== 32'h8) begin
      errors++;
      $display("FAIL oneshot_ctrl_autoclear got %h expected %h", v, 32'h8);
    end
    step(1, 32'h0, 32'h8);
    checks++;
    if (IRQ !== 1'b0) begin
      errors++;
      $display("FAIL oneshot_ack_irq got %b expected 0", IRQ);
    end
  endtask

  task automatic test_periodic();
    logic [31:0] v;
    int pulses = 0;
    step(1, 32'h4, 3);
    step(1, 32'h0, 32'hB);
    for (int k = 1; k <= 20; k++) begin
      step(0, 0, 0);
      rd(2'd2, v);
      checks++;
      if (v !== m_read(2'd2)) begin
        errors++;
        $display("FAIL periodic_count E%0d got %0d expected %0d", k, v, m_read(2'd2));
      end
      checks++;
      if (IRQ !== m_irq()) begin
        errors++;
        $display("FAIL periodic_irq E%0d got %b expected %b", k, IRQ, m_irq());
      end
      if (IRQ === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 4) begin
      errors++;
      $display("FAIL periodic_pulse_count got %0d expected 4", pulses);
    end
    step(1, 32'h0, 32'h0);
  endtask

  task automatic test_disable();
    logic [31:0] v;
    int bound = 0;
    step(1, 32'h4, 10);
    step(1, 32'h0, 32'h9);
    do begin
      step(0, 0, 0);
      rd(2'd2, v);
      bound++;
    end while (v !== 32'd6 && bound < 40);
    checks++;
    if (bound >= 40) begin
      errors++;
      $display("FAIL disable_reach6 timed out, count %0d expected 6", v);
    end
    step(1, 32'h0, 32'h8);
    for (int k = 0; k < 20; k++) begin
      step(0, 0, 0);
      rd(2'd2, v);
      checks++;
      if (v !== 32'd6 || v !== m_read(2'd2)) begin
        errors++;
        $display("FAIL disable_frozen cycle %0d got %0d expected 6", k, v);
      end
      checks++;
      if (IRQ !== 1'b0) begin
        errors++;
        $display("FAIL disable_irq cycle %0d got %b expected 0", k, IRQ);
      end
    end
    step(1, 32'h0, 32'h9);
    step(0, 0, 0);
    step(0, 0, 0);
    rd(2'd2, v);
    checks++;
    if (v !== 32'd10) begin
      errors++;
      $display("FAIL disable_reenable got %0d expected 10", v);
    end
    step(1, 32'h0, 32'h0);
  endtask

  task automatic test_mask();
    logic [31:0] v;
    step(1, 32'h4, 2);
    step(1, 32'h0, 32'h1);
    for (int k = 1; k <= 8; k++) begin
      step(0, 0, 0);
      checks++;
      if (IRQ !== 1'b0) begin
        errors++;
        $display("FAIL mask_irq E%0d got %b expected 0", k, IRQ);
      end
      rd(2'd2, v);
      checks++;
      if (v !== m_read(2'd2)) begin
        errors++;
        $display("FAIL mask_count E%0d got %0d expected %0d", k, v, m_read(2'd2));
      end
    end
    rd(2'd0, v);
    checks++;
    if (v !== 32'h0) begin
      errors++;
      $display("FAIL mask_ctrl_autoclear got %h expected 0", v);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    int bound = 0;
    step(1, 32'h4, 10);
    step(1, 32'h0, 32'h9);
    do begin
      step(0, 0, 0);
      rd(2'd2, v);
      bound++;
    end while (v !== 32'd4 && bound < 40);
    checks++;
    if (bound >= 40) begin
      errors++;
      $display("FAIL resetmid_reach4 timed out, count %0d expected 4", v);
    end
    reset = 1;
    step(0, 0, 0);
    reset = 0;
    for (int s = 0; s < 4; s++) begin
      rd(2'(s), v);
      checks++;
      if (v !== 32'd0) begin
        errors++;
        $display("FAIL resetmid_read[%0d] got %h expected 0", s, v);
      end
    end
    for (int k = 0; k < 5; k++) begin
      step(0, 0, 0);
      rd(2'd2, v);
      checks++;
      if (v !== 32'd0 || IRQ !== 1'b0) begin
        errors++;
        $display("FAIL resetmid_idle cycle %0d count %0d irq %b expected 0 0", k, v, IRQ);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] v;
    logic [31:0] d;
    logic [1:0]  sel;
    bit          we;
    bit          rst;
    for (int c = 0; c < 400; c++) begin
      we  = ($urandom_range(0, 5) == 0);
      sel = 2'($urandom_range(0, 3));
      d   = (sel == 2'd1) ? 32'($urandom_range(0, 6)) : $urandom;
      rst = ($urandom_range(0, 99) == 0);
      reset        = rst;
      write_enable = we;
      write_data   = d;
      addr         = {$urandom, 4'b0000} >> 4 | {28'd0, sel, 2'b00};
      addr[3:2]    = sel;
      #1;
      checks++;
      if (read_data !== m_read(sel)) begin
        errors++;
        $display("FAIL random_preread c%0d sel %0d got %h expected %h", c, sel, read_data, m_read(sel));
      end
      @(posedge clk);
      model_edge(rst, we, sel, d);
      #1;
      reset        = 0;
      write_enable = 0;
      checks++;
      if (IRQ !== m_irq()) begin
        errors++;
        $display("FAIL random_irq c%0d got %b expected %b", c, IRQ, m_irq());
      end
      for (int s = 0; s < 3; s++) begin
        rd(2'(s), v);
        checks++;
        if (v !== m_read(2'(s))) begin
          errors++;
          $display("FAIL random_read c%0d sel %0d got %h expected %h", c, s, v, m_read(2'(s)));
        end
      end
    end
  endtask

  initial begin
    reset        = 1;
    addr         = 0;
    write_enable = 0;
    write_data   = 0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_oneshot();
    test_periodic();
    test_disable();
    test_mask();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
